ball_rx_unpacker: RTL
=====================

# ball_rx_unpacker

Downstream consumer of the I2C slave register bank in the ball hand-off link. Detects completion of a received ball frame (`go_left` rising edge), waits for the slave registers to settle, then captures and decodes them into local ball state. It holds the decoded launch request after a programmable spawn delay until the game logic acknowledges it. While a frame is in flight it asserts `responsing_i2c` so the local sender does not transmit, and it flags frames that arrive while one is still pending.

## Interface
- `Y_MAX`, 479, largest legal ball row; decoded rows above this are clamped to it.
- `SETTLE_CYC`, 2, cycles (≥1) waited after frame detection before sampling the slave registers.
- `SPAWN_DELAY`, 1000, cycles (≥0) between capture and `ball_valid`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `go_left`  in  1  level from the slave; rises once all 5 frame bytes are latched.
- `i_y_pos0`  in  8  slave reg0, ball row bits [7:0].
- `i_y_pos1`  in  8  slave reg1, ball row bits [9:8] in [1:0]; upper bits ignored.
- `i_y_vel`  in  8  slave reg2, vertical velocity (two's complement).
- `i_gravity`  in  8  slave reg3, gravity phase in [1:0].
- `i_is_collusion`  in  8  slave reg4, collision flag in [0].
- `ball_ack`  in  1  game logic consumed the launch request.
- `ball_valid`  out  1  launch request pending.
- `ball_y`  out  10  decoded, clamped ball row.
- `ball_vy`  out  8  decoded velocity.
- `gravity_counter`  out  2  decoded gravity phase.
- `is_collusion`  out  1  decoded collision flag.
- `responsing_i2c`  out  1  high whenever the FSM is not IDLE.
- `overrun`  out  1  sticky; a frame arrived while the FSM was not IDLE.
- `rx_count`  out  8  count of accepted frames, wraps at 255→0.

## Operation
- Edge detect: `go_prev` register; rise = `go_left & ~go_prev`. `go_prev` resets to 1, so a `go_left` already high at reset release does not start a frame.
- FSM states: IDLE, SETTLE, CHECK, DELAY, PEND.
- IDLE: on rise → SETTLE, load settle counter with `SETTLE_CYC-1`.
- SETTLE: decrement the counter. When it reads 0, capture all five inputs → CHECK, and increment `rx_count`.
- CHECK (1 cycle): decode the captured data into the output registers.
  - `ball_y` = {reg1[1:0], reg0}; values > `Y_MAX` are replaced by `Y_MAX`.
  - `ball_vy` = reg2; `gravity_counter` = reg3[1:0]; `is_collusion` = reg4[0].
  - If `SPAWN_DELAY`=0 → PEND; otherwise → DELAY with the counter loaded to `SPAWN_DELAY-1`.
- DELAY: decrement the counter; at 0 → PEND.
- PEND: `ball_valid`=1. When `ball_ack` is sampled high → IDLE.
- `ball_ack` outside PEND is ignored.
- A rise in any state other than IDLE, including the PEND cycle in which the ack is taken, sets `overrun`=1. The frame is dropped; outputs and `rx_count` are unchanged.
- Decoded outputs hold their last value across IDLE; they change only in CHECK.
- Reset mid-operation returns the FSM to IDLE immediately and clears all outputs.

## Timing
- Reset values:
  - `ball_valid`, `ball_y`, `ball_vy`, `gravity_counter`, `is_collusion`, `responsing_i2c`, `overrun`, `rx_count` = 0.
  - FSM = IDLE; `go_prev` = 1.
- Rise sampled at edge E0 → `responsing_i2c`=1 after E0.
- Register capture at edge E0+`SETTLE_CYC`.
- Decoded outputs valid after edge E0+`SETTLE_CYC`+1.
- `ball_valid`=1 after edge E0+`SETTLE_CYC`+1+`SPAWN_DELAY` (defaults: 1003 cycles).
- Ack sampled at edge Ea → `ball_valid`=0 and `responsing_i2c`=0 after Ea.
- A new rise is accepted no earlier than edge Ea+1.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- Reset with `go_left`=1 held, then release → no frame: `rx_count`=0, `responsing_i2c`=0.
- reg0=0x2C, reg1=0x01, reg2=0xFD, reg3=0x02, reg4=0x01, `go_left` 0→1 at E0 (defaults) →
  - `ball_valid` rises after E0+1003;
  - `ball_y`=300, `ball_vy`=0xFD, `gravity_counter`=2, `is_collusion`=1, `rx_count`=1.
- reg1=0x03, reg0=0xFF (row 1023) → `ball_y`=479.
  - reg1=0xFD, reg0=0x10 → `ball_y`=272; the upper bits of reg1 are ignored.
- Second `go_left` rise during DELAY, and another in the same cycle as `ball_ack` →
  - `overrun`=1 for both; `rx_count` unchanged;
  - outputs keep the first frame's values.
- `SPAWN_DELAY`=0, `SETTLE_CYC`=1: rise at E0 → `ball_valid` after E0+2.
  - `ball_ack` held high continuously → `ball_valid` lasts exactly one cycle.
  - 256 back-to-back frames → `rx_count` wraps to 0.
- Assert `reset` while in SETTLE, and again while in PEND → all outputs 0 immediately.
  - The next frame after release decodes normally.

Source files
------------

// File: rtl/ball_rx_unpacker.sv
// Receive-side unpacker for the ball hand-off link: detects a completed slave frame,
// lets the register bank settle, then captures, decodes and holds a launch request.
module ball_rx_unpacker #(
    parameter int Y_MAX       = 479,
    parameter int SETTLE_CYC  = 2,
    parameter int SPAWN_DELAY = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go_left,
    input  logic [7:0] i_y_pos0,
    input  logic [7:0] i_y_pos1,
    input  logic [7:0] i_y_vel,
    input  logic [7:0] i_gravity,
    input  logic [7:0] i_is_collusion,
    input  logic       ball_ack,
    output logic       ball_valid,
    output logic [9:0] ball_y,
    output logic [7:0] ball_vy,
    output logic [1:0] gravity_counter,
    output logic       is_collusion,
    output logic       responsing_i2c,
    output logic       overrun,
    output logic [7:0] rx_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_DELAY  = 3'd3,
        ST_PEND   = 3'd4
    } state_e;

    localparam logic [9:0]  Y_MAX_C     = 10'(Y_MAX);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] SPAWN_LOAD  = (SPAWN_DELAY > 0) ? 32'(SPAWN_DELAY - 1) : 32'd0;

    function automatic logic [9:0] clamp_row(input logic [9:0] raw);
        if (raw > Y_MAX_C) begin
            clamp_row = Y_MAX_C;
        end else begin
            clamp_row = raw;
        end
    endfunction

    state_e      state_q, state_d;
    logic        go_prev_q, go_prev_d;
    logic [31:0] cnt_q, cnt_d;
    logic [9:0]  cap_y_q, cap_y_d;
    logic [7:0]  cap_vy_q, cap_vy_d;
    logic [1:0]  cap_grav_q, cap_grav_d;
    logic        cap_col_q, cap_col_d;
    logic        ball_valid_q, ball_valid_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic [7:0]  ball_vy_q, ball_vy_d;
    logic [1:0]  grav_q, grav_d;
    logic        col_q, col_d;
    logic        resp_q, resp_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rx_count_q, rx_count_d;
    logic        rise_s;

    // Only the low bits of the upper slave registers carry information.
    logic unused_bits_s;
    assign unused_bits_s = ^{i_y_pos1[7:2], i_gravity[7:2], i_is_collusion[7:1]};

    // Next-state, capture, decode and status logic.
    always_comb begin
        state_d      = state_q;
        go_prev_d    = go_left;
        cnt_d        = cnt_q;
        cap_y_d      = cap_y_q;
        cap_vy_d     = cap_vy_q;
        cap_grav_d   = cap_grav_q;
        cap_col_d    = cap_col_q;
        ball_y_d     = ball_y_q;
        ball_vy_d    = ball_vy_q;
        grav_d       = grav_q;
        col_d        = col_q;
        overrun_d    = overrun_q;
        rx_count_d   = rx_count_q;
        rise_s       = go_left & ~go_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 32'd0) begin
                    state_d    = ST_CHECK;
                    cap_y_d    = {i_y_pos1[1:0], i_y_pos0};
                    cap_vy_d   = i_y_vel;
                    cap_grav_d = i_gravity[1:0];
                    cap_col_d  = i_is_collusion[0];
                    rx_count_d = rx_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_CHECK: begin
                ball_y_d  = clamp_row(cap_y_q);
                ball_vy_d = cap_vy_q;
                grav_d    = cap_grav_q;
                col_d     = cap_col_q;
                if (SPAWN_DELAY == 0) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_DELAY;
                    cnt_d   = SPAWN_LOAD;
                end
            end
            ST_DELAY: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_PEND;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_PEND: begin
                if (ball_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A frame landing while one is in flight is dropped but remembered.
        if (rise_s && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        ball_valid_d = (state_d == ST_PEND);
        resp_d       = (state_d != ST_IDLE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            go_prev_q    <= 1'b1;
            cnt_q        <= 32'd0;
            cap_y_q      <= 10'd0;
            cap_vy_q     <= 8'd0;
            cap_grav_q   <= 2'd0;
            cap_col_q    <= 1'b0;
            ball_valid_q <= 1'b0;
            ball_y_q     <= 10'd0;
            ball_vy_q    <= 8'd0;
            grav_q       <= 2'd0;
            col_q        <= 1'b0;
            resp_q       <= 1'b0;
            overrun_q    <= 1'b0;
            rx_count_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            go_prev_q    <= go_prev_d;
            cnt_q        <= cnt_d;
            cap_y_q      <= cap_y_d;
            cap_vy_q     <= cap_vy_d;
            cap_grav_q   <= cap_grav_d;
            cap_col_q    <= cap_col_d;
            ball_valid_q <= ball_valid_d;
            ball_y_q     <= ball_y_d;
            ball_vy_q    <= ball_vy_d;
            grav_q       <= grav_d;
            col_q        <= col_d;
            resp_q       <= resp_d;
            overrun_q    <= overrun_d;
            rx_count_q   <= rx_count_d;
        end
    end

    assign ball_valid      = ball_valid_q;
    assign ball_y          = ball_y_q;
    assign ball_vy         = ball_vy_q;
    assign gravity_counter = grav_q;
    assign is_collusion    = col_q;
    assign responsing_i2c  = resp_q;
    assign overrun         = overrun_q;
    assign rx_count        = rx_count_q;

endmodule
